// File: rtl/interlock_sequencer.sv
// Bathysphere interlock sequencer: turns one-cycle arrive/depart requests into an
// ordered gate and pressure command sequence with dwell timing, timeouts and interlocks.
module interlock_sequencer #(
    parameter int unsigned GATE_TICKS = 2,
    parameter int unsigned TIMEOUT    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       chamber_full,
    input  logic       bath_in_chamber,
    output logic       outer_gate,
    output logic       inner_gate,
    output logic       fill_cmd,
    output logic       empty_cmd,
    output logic       busy,
    output logic       fault,
    output logic [3:0] state_code
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        PRESET      = 4'd1,
        OPEN_ENTRY  = 4'd2,
        WAIT_IN     = 4'd3,
        CLOSE_ENTRY = 4'd4,
        TRANSFER    = 4'd5,
        OPEN_EXIT   = 4'd6,
        WAIT_OUT    = 4'd7,
        CLOSE_EXIT  = 4'd8,
        FAULT       = 4'd15
    } state_e;

    localparam logic [15:0] DWELL_LAST = 16'(GATE_TICKS - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        dir_q, dir_d;
    logic [15:0] cnt_q, cnt_d;
    logic        outer_q, outer_d;
    logic        inner_q, inner_d;
    logic        fill_q, fill_d;
    logic        empty_q, empty_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;

    logic entry_ok, exit_ok, dwell_done, timed_out;
    logic entry_phase, exit_phase, enter_preset, enter_transfer;

    // Arrive enters at full and leaves at empty; depart is the mirror image.
    assign entry_ok   = (chamber_full == ~dir_q);
    assign exit_ok    = (chamber_full == dir_q);
    assign dwell_done = (cnt_q == DWELL_LAST);
    assign timed_out  = (cnt_q == WAIT_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (arrive_req) begin
                    state_d = PRESET;
                    dir_d   = 1'b0;
                end else if (depart_req) begin
                    state_d = PRESET;
                    dir_d   = 1'b1;
                end
            end
            PRESET: begin
                if (entry_ok)       state_d = OPEN_ENTRY;
                else if (timed_out) state_d = FAULT;
            end
            OPEN_ENTRY: begin
                if (!entry_ok)       state_d = FAULT;
                else if (dwell_done) state_d = WAIT_IN;
            end
            WAIT_IN: begin
                if (!entry_ok)            state_d = FAULT;
                else if (bath_in_chamber) state_d = CLOSE_ENTRY;
                else if (timed_out)       state_d = FAULT;
            end
            CLOSE_ENTRY: if (dwell_done) state_d = TRANSFER;
            TRANSFER: begin
                if (exit_ok)        state_d = OPEN_EXIT;
                else if (timed_out) state_d = FAULT;
            end
            OPEN_EXIT: begin
                if (!exit_ok)        state_d = FAULT;
                else if (dwell_done) state_d = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (!exit_ok)              state_d = FAULT;
                else if (!bath_in_chamber) state_d = CLOSE_EXIT;
                else if (timed_out)        state_d = FAULT;
            end
            CLOSE_EXIT: if (dwell_done) state_d = IDLE;
            FAULT:      state_d = FAULT;
            default:    state_d = FAULT;
        endcase
    end

    // Output flops are loaded from the next state so they always match state_q.
    always_comb begin
        entry_phase    = (state_d == OPEN_ENTRY) || (state_d == WAIT_IN);
        exit_phase     = (state_d == OPEN_EXIT)  || (state_d == WAIT_OUT);
        enter_preset   = (state_d == PRESET)   && (state_q != PRESET);
        enter_transfer = (state_d == TRANSFER) && (state_q != TRANSFER);

        if ((state_d != state_q) || (state_q == IDLE) || (state_q == FAULT)) cnt_d = '0;
        else                                                                  cnt_d = cnt_q + 16'd1;

        outer_d = (~dir_d & entry_phase) | (dir_d & exit_phase);
        inner_d = (dir_d & entry_phase) | (~dir_d & exit_phase);
        fill_d  = (enter_preset & ~dir_d & ~chamber_full) | (enter_transfer & dir_d);
        empty_d = (enter_preset & dir_d & chamber_full) | (enter_transfer & ~dir_d);
        busy_d  = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            outer_q <= 1'b0;
            inner_q <= 1'b0;
            fill_q  <= 1'b0;
            empty_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            fill_q  <= fill_d;
            empty_q <= empty_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    // A gate whose pressure condition fails is dropped in the same cycle.
    assign outer_gate = outer_q & chamber_full;
    assign inner_gate = inner_q & ~chamber_full;
    assign fill_cmd   = fill_q;
    assign empty_cmd  = empty_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign state_code = state_q;

endmodule

// File: doc/interlock_sequencer.md
# interlock_sequencer

Automatic sequencer for the bathysphere interlock. It converts one-cycle arrival/departure requests into a safe ordered sequence of gate and pressure commands. The pressure controller and bathysphere location logic sit downstream; the sequencer consumes their chamber-full and bathysphere-in-chamber status. The sequencer replaces manual switch and key operation of the gates and the fill/empty signals.

## Interface

- GATE_TICKS, 2: cycles a gate command is held before the gate counts as moved (open or closed).
- TIMEOUT, 20: maximum cycles allowed in any wait state before FAULT. Must be 1..65535.
- clk  input  1  system clock. The divided slow clock is used in the top level.
- reset  input  1  asynchronous, active-low reset.
- arrive_req  input  1  one-cycle request: bathysphere arriving from sea.
- depart_req  input  1  one-cycle request: bathysphere departing to sea.
- chamber_full  input  1  pressure controller status: 1 when the chamber is flooded.
- bath_in_chamber  input  1  location status: 1 when the bathysphere is inside the chamber.
- outer_gate  output  1  1 commands the sea-side gate open.
- inner_gate  output  1  1 commands the habitat-side gate open.
- fill_cmd  output  1  one-cycle pulse: start filling.
- empty_cmd  output  1  one-cycle pulse: start emptying.
- busy  output  1  1 in any state other than IDLE.
- fault  output  1  1 in FAULT.
- state_code  output  4  current state encoding, for the HEX display.

## Operation

- Reset (reset=0, asynchronous):
  - state is IDLE (0).
  - All outputs are 0.
  - The dir register and the 16-bit counter cnt are 0.
- Direction register dir is latched when the sequencer leaves IDLE: 0 for arrive, 1 for depart.
- Each direction has an entry gate, an exit gate and a required entry level:
  - Arrive (dir=0): entry gate is outer, exit gate is inner, entry level is full.
  - Depart (dir=1): entry gate is inner, exit gate is outer, entry level is empty.
- States and transitions:
  - IDLE(0): on arrive_req go to PRESET with dir=0. Otherwise, on depart_req go to PRESET with dir=1. Arrive wins if both are high in the same cycle.
  - PRESET(1): if chamber_full already equals the entry level, go to OPEN_ENTRY. Otherwise pulse the matching command (fill for full, empty for empty) and wait until chamber_full matches.
  - OPEN_ENTRY(2): entry gate asserted. Hold for GATE_TICKS cycles, then go to WAIT_IN.
  - WAIT_IN(3): entry gate asserted. Go to CLOSE_ENTRY when bath_in_chamber=1.
  - CLOSE_ENTRY(4): entry gate deasserted. Hold for GATE_TICKS cycles, then go to TRANSFER.
  - TRANSFER(5): pulse the opposite command (empty for arrive, fill for depart). Wait until chamber_full equals the exit level (the inverse of the entry level), then go to OPEN_EXIT.
  - OPEN_EXIT(6): exit gate asserted. Hold for GATE_TICKS cycles, then go to WAIT_OUT.
  - WAIT_OUT(7): exit gate asserted. Go to CLOSE_EXIT when bath_in_chamber=0.
  - CLOSE_EXIT(8): exit gate deasserted. Hold for GATE_TICKS cycles, then go to IDLE.
  - FAULT(15): both gates 0, no pulses. Left only by reset.
- Safety invariants, enforced at every cycle:
  - outer_gate and inner_gate are never both 1.
  - outer_gate=1 only while chamber_full=1.
  - inner_gate=1 only while chamber_full=0.
  - If an open gate sees its pressure condition violated, next state is FAULT and the gate drops that cycle.
- Timeout: cnt counts cycles in PRESET, TRANSFER, WAIT_IN and WAIT_OUT. If cnt reaches TIMEOUT while still waiting, next state is FAULT.
- Requests arriving while busy=1 are ignored and not queued.

## Timing

- All outputs are registered and reflect the current state. All state changes occur on the rising edge of clk.
- cnt clears on every state change. Gate dwell states last exactly GATE_TICKS cycles.
- Request latency: a request sampled high at edge n puts the sequencer in PRESET from edge n.
- PRESET with level already correct lasts exactly 1 cycle with no pulse.
- fill_cmd and empty_cmd are high exactly during the first cycle of PRESET or TRANSFER, never longer. They are never both high.
- A wait condition already true on the first cycle of a wait state exits at the next edge.
- Timeout: FAULT is entered at the edge where cnt would equal TIMEOUT. The maximum time in a wait state is TIMEOUT cycles.
- Asserting reset mid-sequence forces IDLE immediately. Gates drop asynchronously and no pulse is issued.

## Test plan

- Reset: hold reset=0 with random inputs → all outputs 0, state_code=0. Release reset, apply no requests → still idle.
- Arrival with chamber_full=1, GATE_TICKS=2:
  - arrive_req → state_code steps 1,2,2,3.
  - Set bath_in_chamber=1 → sequence continues 4,4,5 with empty_cmd pulsed once.
  - Drop chamber_full → 6,6,7 with inner_gate=1.
  - Clear bath_in_chamber → 8,8,0.
- Departure with chamber_full=1: depart_req → empty_cmd pulse in PRESET. inner_gate stays 0 until chamber_full=0, then the mirrored sequence ends with outer_gate opening only after fill_cmd and chamber_full=1.
- Timeout: arrival with chamber_full stuck 0, TIMEOUT=20 → fill_cmd pulses once, FAULT (state 15, fault=1) after 20 cycles, gates 0.
- Interlock violation: drop chamber_full during WAIT_IN of an arrival → outer_gate 0 and state 15 on the next edge.
- Simultaneous and late requests:
  - arrive_req and depart_req in the same cycle → dir=0.
  - A further depart_req while busy → ignored, no second sequence.
  - reset pulsed in state 5 → state 0 immediately.
